// File: rtl/count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// count_seq_ctrl
//   Command sequencer placed directly upstream of a WIDTH-bit loadable,
//   enabled counter. Accepts LOAD / RUN_TO / ABORT commands over a
//   valid/ready handshake, drives the counter's load/enable/data inputs and
//   watches its count output. Emits a one-cycle done pulse on completion.
//
// Ports
//   i_clock      system clock, rising edge
//   i_rst_n      asynchronous active-low reset (shared with the counter)
//   i_cmd_valid  command present
//   o_cmd_ready  command accepted on the edge where valid && ready
//   i_cmd_op     00 NOP, 01 LOAD, 10 RUN_TO, 11 ABORT
//   i_cmd_arg    LOAD value or RUN_TO target
//   o_load       counter load strobe
//   o_enable     counter count enable
//   o_data       counter load data
//   i_count      counter count output
//   o_busy       sequencer not idle
//   o_done       one-cycle completion pulse
//   o_err        sticky flag: command issued while a run was in progress
// ---------------------------------------------------------------------------
module count_seq_ctrl #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_arg,
  output logic             o_load,
  output logic             o_enable,
  output logic [WIDTH-1:0] o_data,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_RUN_TO = 2'b10,
    OP_ABORT  = 2'b11
  } op_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] target_q;
  logic             err_q;

  op_t  op;
  logic accept;
  logic abort_req;
  logic hit;

  assign op        = op_t'(i_cmd_op);
  assign accept    = i_cmd_valid && o_cmd_ready;
  // ready is always high in RUN, so a valid ABORT there is always accepted
  assign abort_req = i_cmd_valid && (op == OP_ABORT);
  assign hit       = (i_count == target_q);

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      data_q   <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_LOAD: begin
                data_q <= i_cmd_arg;
                state  <= ST_LOAD;
              end
              OP_RUN_TO: begin
                target_q <= i_cmd_arg;
                state    <= ST_RUN;
              end
              OP_NOP:   err_q <= 1'b0;
              default: ;  // ABORT while idle does nothing
            endcase
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_RUN: begin
          // ABORT has priority over a simultaneous target hit
          if (abort_req) begin
            state <= ST_IDLE;
          end else begin
            if (hit)         state <= ST_DONE;
            if (i_cmd_valid) err_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register; enable is the only output
  // that must also look at the live count and command inputs.
  assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);
  assign o_load      = (state == ST_LOAD);
  assign o_enable    = (state == ST_RUN) && !hit && !abort_req;
  assign o_data      = data_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_seq_ctrl
//   Directed bench for count_seq_ctrl. A behavioural 5-bit loadable counter
//   closes the loop between o_load/o_enable/o_data and i_count. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_count_seq_ctrl;

  localparam int unsigned WIDTH = 5;

  localparam logic [1:0] NOP    = 2'b00;
  localparam logic [1:0] LOAD   = 2'b01;
  localparam logic [1:0] RUN_TO = 2'b10;
  localparam logic [1:0] ABORT  = 2'b11;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             err;

  int vectors;
  int miscompares;

  // observation accumulators filled by observe()
  int en_cnt;
  int done_cnt;
  int ld_cnt;
  int overlap_cnt;
  logic [WIDTH-1:0] count_at_done;

  count_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clock     (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_arg   (cmd_arg),
    .o_load      (load),
    .o_enable    (enable),
    .o_data      (data),
    .i_count     (count),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter model sharing the reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (load)   count <= data;
    else if (enable) count <= count + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one command across a single rising edge; ready must be high
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    #1;
    chk("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  // sample outputs for n falling edges, accumulating event counts
  task automatic observe(input int n);
    en_cnt = 0; done_cnt = 0; ld_cnt = 0; overlap_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (enable) en_cnt++;
      if (load)   ld_cnt++;
      if (enable && load) overlap_cnt++;
      if (done) begin
        done_cnt++;
        count_at_done = count;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    issue(LOAD, v);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = NOP;
    cmd_arg     = '0;
    count_at_done = '0;

    // reset state
    #1;
    chk("rst_ready",  {31'd0, cmd_ready}, 32'd1);
    chk("rst_load",   {31'd0, load},      32'd0);
    chk("rst_enable", {31'd0, enable},    32'd0);
    chk("rst_data",   {27'd0, data},      32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_done",   {31'd0, done},      32'd0);
    chk("rst_err",    {31'd0, err},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 7: load for one cycle, done two cycles after accept
    issue(LOAD, 5'd7);
    chk("ld_load_hi",   {31'd0, load},      32'd1);
    chk("ld_data",      {27'd0, data},      32'd7);
    chk("ld_enable_lo", {31'd0, enable},    32'd0);
    chk("ld_busy",      {31'd0, busy},      32'd1);
    chk("ld_ready_lo",  {31'd0, cmd_ready}, 32'd0);
    chk("ld_done_lo",   {31'd0, done},      32'd0);
    @(negedge clk);
    chk("ld_load_lo",   {31'd0, load},      32'd0);
    chk("ld_done_hi",   {31'd0, done},      32'd1);
    chk("ld_count",     {27'd0, count},     32'd7);
    chk("ld_ready_dn",  {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ld_done_end",  {31'd0, done},      32'd0);
    chk("ld_idle",      {31'd0, busy},      32'd0);
    chk("ld_ready_end", {31'd0, cmd_ready}, 32'd1);

    // RUN_TO 12 from 7: five enables, one done, no overshoot
    issue(RUN_TO, 5'd12);
    observe(20);
    chk("run12_enables", en_cnt,             32'd5);
    chk("run12_done",    done_cnt,           32'd1);
    chk("run12_cnt_dn",  {27'd0, count_at_done}, 32'd12);
    chk("run12_count",   {27'd0, count},     32'd12);
    chk("run12_overlap", overlap_cnt,        32'd0);
    chk("run12_idle",    {31'd0, busy},      32'd0);

    // RUN_TO 2 from 30: wraps, four enables
    do_load(5'd30);
    chk("wrap_start", {27'd0, count}, 32'd30);
    issue(RUN_TO, 5'd2);
    observe(20);
    chk("wrap_enables", en_cnt,         32'd4);
    chk("wrap_done",    done_cnt,       32'd1);
    chk("wrap_count",   {27'd0, count}, 32'd2);

    // RUN_TO 9 from 9: zero enables, done one cycle later
    do_load(5'd9);
    issue(RUN_TO, 5'd9);
    chk("zero_enable", {31'd0, enable}, 32'd0);
    chk("zero_busy",   {31'd0, busy},   32'd1);
    chk("zero_done0",  {31'd0, done},   32'd0);
    @(negedge clk);
    chk("zero_done1",  {31'd0, done},   32'd1);
    @(negedge clk);
    chk("zero_idle",   {31'd0, busy},   32'd0);
    chk("zero_count",  {27'd0, count},  32'd9);

    // RUN_TO 20 from 9, ABORT after three enables
    issue(RUN_TO, 5'd20);
    observe(3);
    chk("abort_pre_en", en_cnt, 32'd3);
    cmd_valid = 1'b1;
    cmd_op    = ABORT;
    #1;
    chk("abort_en_lo", {31'd0, enable},    32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    chk("abort_idle",  {31'd0, busy},  32'd0);
    chk("abort_count", {27'd0, count}, 32'd12);
    observe(5);
    chk("abort_no_done", done_cnt,       32'd0);
    chk("abort_no_en",   en_cnt,         32'd0);
    chk("abort_held",    {27'd0, count}, 32'd12);

    // LOAD during RUN: dropped, sticky err, run completes
    issue(RUN_TO, 5'd15);
    cmd_valid = 1'b1;
    cmd_op    = LOAD;
    cmd_arg   = 5'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    chk("mid_err",  {31'd0, err},  32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    observe(10);
    chk("mid_enables", en_cnt,         32'd2);
    chk("mid_no_load", ld_cnt,         32'd0);
    chk("mid_done",    done_cnt,       32'd1);
    chk("mid_count",   {27'd0, count}, 32'd15);
    chk("mid_err_idle",{31'd0, err},   32'd1);
    issue(ABORT, 5'd0);
    chk("abort_keeps_err", {31'd0, err}, 32'd1);
    issue(NOP, 5'd0);
    chk("nop_clr_err",     {31'd0, err}, 32'd0);

    // async reset mid-run (15 -> 5 wraps, long run)
    issue(RUN_TO, 5'd5);
    observe(2);
    chk("rr_running", {31'd0, enable}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rr_enable", {31'd0, enable}, 32'd0);
    chk("rr_busy",   {31'd0, busy},   32'd0);
    chk("rr_done",   {31'd0, done},   32'd0);
    chk("rr_load",   {31'd0, load},   32'd0);
    chk("rr_count",  {27'd0, count},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_ready",  {31'd0, cmd_ready}, 32'd1);
    chk("rr_data",   {27'd0, data},      32'd0);
    chk("rr_idle",   {31'd0, busy},      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
